reaction_trial_sequencer: RTL and testbench
===========================================

Name: reaction_trial_sequencer

Overview:
- Controller that sequences a multi-trial reaction-time session around the existing LFSR, stopwatch and 7-segment datapath.
- Per trial it loads a random pre-delay, counts it down, then lights the LED and times the reaction in 10 ms ticks.
- It handles false starts and timeouts, and accumulates per-trial results, best time and session average.
- Sits between the debounced button pulses / LFSR and the display mux; outputs drive display select and result digits.

Parameters:
- TICK_DIV, 500000, clock cycles per 10 ms tick (50 MHz clock).
- MIN_DELAY_T, 100, minimum pre-delay in ticks (1.00 s).
- DLY_W, 8, LFSR bits added to pre-delay (0..255 extra ticks).
- MAX_REACT_T, 999, reaction timeout in ticks; also the saturation value.
- LOG2_TRIALS, 2, trials per session = 2**LOG2_TRIALS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_p  in  1  one-cycle debounced start pulse.
- stop_p  in  1  one-cycle debounced stop pulse.
- rand_val  in  29  free-running LFSR value; low DLY_W bits are used.
- led  out  1  react stimulus LED.
- disp_sel  out  2  display mux select: 00 = HI, 01 = live/result, 10 = average, 11 = fault "--".
- cur_cs  out  10  current/last reaction time in ticks (binary).
- best_cs  out  10  best valid time this session.
- avg_cs  out  10  session average.
- trial_idx  out  LOG2_TRIALS  index of current trial.
- result_valid  out  1  one-cycle pulse when a trial result is recorded.
- session_done  out  1  level, high in DONE.

Behaviour:
- Reset (reset = 0) puts outputs to: state IDLE, led 0, disp_sel 00, cur_cs 0, best_cs MAX_REACT_T, avg_cs 0, trial_idx 0, result_valid 0, session_done 0, sum 0, prescaler 0.
- Prescaler counts 0..TICK_DIV-1. tick is asserted when prescaler == TICK_DIV-1. The prescaler clears on entry to WAIT and to REACT.
- IDLE: on start_p, latch delay = MIN_DELAY_T + rand_val[DLY_W-1:0], clear sum/trial_idx, set best_cs = MAX_REACT_T, go to WAIT.
- WAIT:
  - Each tick decrements delay.
  - When delay == 0 on a tick, go to REACT next cycle: led = 1, cur_cs = 0, disp_sel 01.
  - stop_p in WAIT is a false start: go to FAULT, disp_sel 11.
- REACT:
  - Each tick does cur_cs + 1.
  - stop_p goes to RECORD with cur_cs as currently registered; a tick in the same cycle is discarded.
  - A tick while cur_cs == MAX_REACT_T goes to RECORD with cur_cs = MAX_REACT_T (timeout).
  - led is 1 only while in REACT.
- RECORD (1 cycle):
  - sum += cur_cs.
  - best_cs = min(best_cs, cur_cs).
  - result_valid = 1.
  - If trial_idx == 2**LOG2_TRIALS-1, go to DONE; otherwise trial_idx + 1 and go to SHOW.
- SHOW: disp_sel 01 showing cur_cs. start_p latches a new delay and goes to WAIT.
- FAULT: trial is not counted. start_p re-latches delay and goes to WAIT with the same trial_idx.
- DONE:
  - avg_cs = sum >> LOG2_TRIALS (truncate), registered on entry.
  - disp_sel 10, session_done 1.
  - start_p goes to IDLE-equivalent restart: clear sum and a new session begins in WAIT.
- Widths:
  - sum is 10+LOG2_TRIALS bits and never overflows.
  - delay counter is width of MIN_DELAY_T + 2**DLY_W - 1.
- Priority:
  - stop_p over start_p in the same cycle.
  - start_p is ignored in WAIT/REACT/RECORD.
  - stop_p is ignored in IDLE/SHOW/FAULT/DONE.
- Reset mid-trial returns everything to the reset values immediately.

Optional Feature:
- Macro FALSE_START_PENALTY_EN.
- Defined: a false start in WAIT goes to RECORD with cur_cs = MAX_REACT_T, counted as a trial (led stays 0). The FAULT state is still shown for one SHOW period via disp_sel 11 until start_p.
- Undefined: FAULT behaviour as above, and the trial is retried.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WAIT, REACT, RECORD, SHOW, FAULT, DONE);
  - disp_sel codes (DISP_HI, DISP_TIME, DISP_AVG, DISP_FAULT);
  - default TICK_DIV.
- Natural sub-module: reaction_tick_gen (prescaler with sync clear, tick output), reused by the stopwatch.

Test Plan:
- Use TICK_DIV=4, MIN_DELAY_T=3, DLY_W=2, MAX_REACT_T=20, LOG2_TRIALS=2 for all scenarios.
- Normal trial: rand_val[1:0]=2, start_p, stop_p 7 ticks after led rises -> delay 5 ticks before led=1; cur_cs=7; result_valid one pulse; trial_idx=1; disp_sel=01.
- Session average: 4 trials with 7, 9, 12, 4 ticks -> best_cs=4, avg_cs=8 (32>>2), session_done=1, disp_sel=10.
- False start: stop_p 2 ticks into WAIT -> led never 1, disp_sel=11, trial_idx unchanged. With FALSE_START_PENALTY_EN: cur_cs=20 and trial_idx+1.
- Timeout: no stop_p after led -> cur_cs saturates at 20, RECORD on the next tick, led=0, result_valid pulse.
- Simultaneous: stop_p in the same cycle as a REACT tick with cur_cs=5 -> recorded 5. start_p together with stop_p in REACT -> start ignored.
- Async reset asserted mid-REACT -> led=0, disp_sel=00, best_cs=20 within the same cycle without a clock edge.

Source files
------------

// File: rtl/reaction_trial_sequencer_pkg.sv
// Shared types and defaults for the reaction-time trial sequencer and its tick generator.
package reaction_trial_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REACT,
      ST_RECORD,
      ST_SHOW,
      ST_FAULT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      DISP_HI    = 2'b00,
      DISP_TIME  = 2'b01,
      DISP_AVG   = 2'b10,
      DISP_FAULT = 2'b11
   } disp_t;

   localparam int DEF_TICK_DIV = 500000;

endpackage

// File: rtl/reaction_trial_sequencer_if.sv
// Button/LFSR inputs and display/result outputs of the reaction-time sequencer.
interface reaction_trial_sequencer_if #(
   parameter int LOG2_TRIALS = 2
);
   logic                   start_p;
   logic                   stop_p;
   logic [28:0]            rand_val;
   logic                   led;
   logic [1:0]             disp_sel;
   logic [9:0]             cur_cs;
   logic [9:0]             best_cs;
   logic [9:0]             avg_cs;
   logic [LOG2_TRIALS-1:0] trial_idx;
   logic                   result_valid;
   logic                   session_done;

   modport master (
      output start_p, stop_p, rand_val,
      input  led, disp_sel, cur_cs, best_cs, avg_cs, trial_idx, result_valid, session_done
   );

   modport slave (
      input  start_p, stop_p, rand_val,
      output led, disp_sel, cur_cs, best_cs, avg_cs, trial_idx, result_valid, session_done
   );
endinterface

// File: rtl/reaction_tick_gen.sv
// 10 ms tick prescaler: counts 0..TICK_DIV-1, tick on the last count, synchronous clear.
module reaction_tick_gen
   import reaction_trial_sequencer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr || cnt_q == TC) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PW'(1);
      end
   end

   assign tick = (cnt_q == TC);
endmodule

// File: rtl/reaction_trial_sequencer.sv
// Multi-trial reaction-time session controller: random pre-delay, reaction timing, best/average.
// Build option FALSE_START_PENALTY_EN: a false start records MAX_REACT_T as a counted trial.
//
// state  | meaning
// IDLE   | waiting for first start after reset
// WAIT   | counting down the random pre-delay, LED off
// REACT  | LED on, counting reaction ticks
// RECORD | one cycle: accumulate sum/best, pulse result_valid
// SHOW   | showing last trial time, start begins next trial
// FAULT  | false start shown, start retries the same trial
// DONE   | session average shown, start begins a new session
module reaction_trial_sequencer
   import reaction_trial_sequencer_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int MIN_DELAY_T = 100,
   parameter int DLY_W       = 8,
   parameter int MAX_REACT_T = 999,
   parameter int LOG2_TRIALS = 2
) (
   input logic                       clock,
   input logic                       reset,
   reaction_trial_sequencer_if.slave bus
);
   localparam int DW = $clog2(MIN_DELAY_T + (1 << DLY_W));
   localparam int SW = 10 + LOG2_TRIALS;
   localparam logic [9:0] MAX_CS = 10'(MAX_REACT_T);
   localparam logic [LOG2_TRIALS-1:0] LAST_TRIAL = '1;
`ifdef FALSE_START_PENALTY_EN
   localparam state_t FS_DEST = ST_RECORD;
`else
   localparam state_t FS_DEST = ST_FAULT;
`endif

   state_t                 state_q, state_nx;
   disp_t                  disp;
   logic [DW-1:0]          delay_q;
   logic [9:0]             cur_q, best_q, avg_q;
   logic [SW-1:0]          sum_q, sum_nx;
   logic [LOG2_TRIALS-1:0] trial_q;
   logic                   tick, tick_clr, start_ok, fault_q;
   logic                   unused_rand;

   reaction_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      disp     = DISP_HI;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_p) state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.stop_p)                              state_nx = FS_DEST;
            else if (tick && delay_q <= DW'(1))          state_nx = ST_REACT;
         end
         ST_REACT: begin
            disp = DISP_TIME;
            if (bus.stop_p || (tick && cur_q == MAX_CS)) state_nx = ST_RECORD;
         end
         ST_RECORD: begin
            disp     = fault_q ? DISP_FAULT : DISP_TIME;
            state_nx = (trial_q == LAST_TRIAL) ? ST_DONE : ST_SHOW;
         end
         ST_SHOW: begin
            disp = fault_q ? DISP_FAULT : DISP_TIME;
            if (bus.start_p) state_nx = ST_WAIT;
         end
         ST_FAULT: begin
            disp = DISP_FAULT;
            if (bus.start_p) state_nx = ST_WAIT;
         end
         ST_DONE: begin
            disp = DISP_AVG;
            if (bus.start_p) state_nx = ST_WAIT;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign start_ok = (state_nx == ST_WAIT) && (state_q != ST_WAIT);
   assign tick_clr = (state_nx != state_q) && (state_nx == ST_WAIT || state_nx == ST_REACT);
   assign sum_nx   = sum_q + SW'(cur_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         delay_q <= '0;
         cur_q   <= '0;
         best_q  <= MAX_CS;
         avg_q   <= '0;
         sum_q   <= '0;
         trial_q <= '0;
      end else begin
         if (start_ok) begin
            delay_q <= DW'(MIN_DELAY_T) + DW'(bus.rand_val[DLY_W-1:0]);
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
               sum_q   <= '0;
               trial_q <= '0;
               best_q  <= MAX_CS;
            end
         end else if (state_q == ST_WAIT && tick) begin
            delay_q <= delay_q - DW'(1);
         end

         // A false start that is counted records the timeout value.
         if (state_q == ST_WAIT && state_nx == ST_REACT)        cur_q <= '0;
         else if (state_q == ST_WAIT && state_nx == ST_RECORD)  cur_q <= MAX_CS;
         else if (state_q == ST_REACT && state_nx == ST_REACT && tick) cur_q <= cur_q + 10'd1;

         if (state_q == ST_RECORD) begin
            sum_q <= sum_nx;
            if (cur_q < best_q) best_q <= cur_q;
            if (state_nx == ST_DONE) avg_q   <= 10'(sum_nx >> LOG2_TRIALS);
            else                     trial_q <= trial_q + LOG2_TRIALS'(1);
         end
      end
   end

`ifdef FALSE_START_PENALTY_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                           fault_q <= 1'b0;
      else if (state_q == ST_WAIT && state_nx == ST_RECORD) fault_q <= 1'b1;
      else if (start_ok)                                    fault_q <= 1'b0;
   end
`else
   assign fault_q = 1'b0;
`endif

   assign unused_rand      = ^bus.rand_val[28:DLY_W];
   assign bus.led          = (state_q == ST_REACT);
   assign bus.disp_sel     = disp;
   assign bus.cur_cs       = cur_q;
   assign bus.best_cs      = best_q;
   assign bus.avg_cs       = avg_q;
   assign bus.trial_idx    = trial_q;
   assign bus.result_valid = (state_q == ST_RECORD);
   assign bus.session_done = (state_q == ST_DONE);
endmodule

// File: tb/tb_reaction_trial_sequencer.sv
// Self-checking bench for reaction_trial_sequencer against a trial-level session model.
module tb_reaction_trial_sequencer;
   localparam int TICK_DIV    = 4;
   localparam int MIN_DELAY_T = 3;
   localparam int DLY_W       = 2;
   localparam int MAX_REACT_T = 20;
   localparam int LOG2_TRIALS = 2;
   localparam int N_TRIALS    = 1 << LOG2_TRIALS;

   logic clock = 1'b0;
   logic reset = 1'b0;

   reaction_trial_sequencer_if #(.LOG2_TRIALS(LOG2_TRIALS)) bus ();

   reaction_trial_sequencer #(
      .TICK_DIV    (TICK_DIV),
      .MIN_DELAY_T (MIN_DELAY_T),
      .DLY_W       (DLY_W),
      .MAX_REACT_T (MAX_REACT_T),
      .LOG2_TRIALS (LOG2_TRIALS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // session model: results of recorded trials only
   int m_sum, m_best, m_idx, m_avg;
   bit m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mdl_new_session();
      m_sum  = 0;
      m_best = MAX_REACT_T;
      m_idx  = 0;
      m_done = 0;
   endtask

   task automatic mdl_record(input int v);
      m_sum += v;
      if (v < m_best) m_best = v;
      if (m_idx == N_TRIALS - 1) begin
         m_done = 1;
         m_avg  = m_sum / N_TRIALS;
      end else begin
         m_idx++;
      end
   endtask

   task automatic post_record(input int exp_cur, input int show_disp);
      step();
      chk("rv_one_cycle", bus.result_valid, 0);
      chk("best", bus.best_cs, m_best);
      chk("led_after_record", bus.led, 0);
      if (m_done) begin
         chk("done_level", bus.session_done, 1);
         chk("done_disp", bus.disp_sel, 2);
         chk("avg", bus.avg_cs, m_avg);
         chk("done_idx", bus.trial_idx, N_TRIALS - 1);
      end else begin
         chk("show_idx", bus.trial_idx, m_idx);
         chk("show_disp", bus.disp_sel, show_disp);
         chk("show_cur", bus.cur_cs, exp_cur);
         chk("show_not_done", bus.session_done, 0);
      end
   endtask

   task automatic start_and_wait_led(input logic [28:0] rnd, output bit ok);
      int n;
      int exp_dly;
      exp_dly      = MIN_DELAY_T + int'(rnd[DLY_W-1:0]);
      bus.rand_val = rnd;
      bus.start_p  = 1'b1;
      step();
      bus.start_p  = 1'b0;
      chk("wait_disp", bus.disp_sel, 0);
      chk("wait_led", bus.led, 0);
      chk("wait_idx", bus.trial_idx, m_idx);
      chk("wait_best", bus.best_cs, m_best);
      chk("wait_not_done", bus.session_done, 0);
      n = 0;
      while (n < 2000 && !bus.led) begin
         step();
         n++;
      end
      chk("led_latency", n, exp_dly * TICK_DIV);
      ok = bus.led;
      chk("react_disp", bus.disp_sel, 1);
      chk("react_cur0", bus.cur_cs, 0);
   endtask

   // react > MAX_REACT_T means no stop press (timeout); j in 1..TICK_DIV is the
   // stop position inside the tick period, j == TICK_DIV coincides with a tick
   task automatic do_trial(input logic [28:0] rnd, input int react, input int j, input bit with_start);
      bit ok;
      int n;
      int exp_v;
      start_and_wait_led(rnd, ok);
      if (react > MAX_REACT_T) begin
         n = 0;
         while (n < 2000 && !bus.result_valid) begin
            step();
            n++;
         end
         chk("timeout_edges", n, (MAX_REACT_T + 1) * TICK_DIV);
         exp_v = MAX_REACT_T;
      end else begin
         repeat (react * TICK_DIV + j - 1) step();
         chk("led_hold", bus.led, 1);
         bus.stop_p  = 1'b1;
         bus.start_p = with_start;
         step();
         bus.stop_p  = 1'b0;
         bus.start_p = 1'b0;
         exp_v = react;
      end
      chk("rv_pulse", bus.result_valid, 1);
      chk("record_cur", bus.cur_cs, exp_v);
      chk("record_led", bus.led, 0);
      chk("record_idx", bus.trial_idx, m_idx);
      mdl_record(exp_v);
      post_record(exp_v, 1);
   endtask

   task automatic do_false_start(input logic [28:0] rnd);
      bit led_seen;
      led_seen     = 0;
      bus.rand_val = rnd;
      bus.start_p  = 1'b1;
      step();
      bus.start_p  = 1'b0;
      repeat (2 * TICK_DIV) begin
         step();
         if (bus.led) led_seen = 1;
      end
      bus.stop_p = 1'b1;
      step();
      bus.stop_p = 1'b0;
      chk("fs_led", {31'd0, led_seen | bus.led}, 0);
      chk("fs_idx", bus.trial_idx, m_idx);
`ifdef FALSE_START_PENALTY_EN
      chk("fs_rv", bus.result_valid, 1);
      chk("fs_cur", bus.cur_cs, MAX_REACT_T);
      mdl_record(MAX_REACT_T);
      post_record(MAX_REACT_T, 3);
`else
      chk("fs_rv", bus.result_valid, 0);
      chk("fs_disp", bus.disp_sel, 3);
      step();
      chk("fs_hold_disp", bus.disp_sel, 3);
      chk("fs_hold_idx", bus.trial_idx, m_idx);
`endif
   endtask

   initial begin
      int plan_v [5];
      int plan_j [5];
      bit plan_s [5];
      int fs_cnt;
      int guard;
      bit ok;
      logic [28:0] rnd;

      plan_v = '{7, -1, 9, 12, 4};
      plan_j = '{2, 0, TICK_DIV, 1, 3};
      plan_s = '{0, 0, 1, 0, 0};

      bus.start_p  = 1'b0;
      bus.stop_p   = 1'b0;
      bus.rand_val = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_led", bus.led, 0);
      chk("rst_disp", bus.disp_sel, 0);
      chk("rst_cur", bus.cur_cs, 0);
      chk("rst_best", bus.best_cs, MAX_REACT_T);
      chk("rst_avg", bus.avg_cs, 0);
      chk("rst_idx", bus.trial_idx, 0);
      chk("rst_rv", bus.result_valid, 0);
      chk("rst_done", bus.session_done, 0);
      reset = 1'b1;
      step();

      // stop in IDLE is ignored
      bus.stop_p = 1'b1;
      step();
      bus.stop_p = 1'b0;
      chk("idle_stop_ignored", bus.disp_sel, 0);

      // session 1: directed trials, false start, stop coinciding with a tick plus start
      mdl_new_session();
      for (int k = 0; k < 5; k++) begin
         if (!m_done) begin
            rnd = 29'($urandom);
            if (k == 0) rnd[1:0] = 2'd2;
            if (plan_v[k] < 0) do_false_start(rnd);
            else               do_trial(rnd, plan_v[k], plan_j[k], plan_s[k]);
         end
      end
      chk("s1_done", {31'd0, m_done}, 1);

      // stop in DONE is ignored
      bus.stop_p = 1'b1;
      step();
      bus.stop_p = 1'b0;
      chk("done_stop_ignored", bus.session_done, 1);

      // session 2: random reaction times, stop phases and occasional false starts
      mdl_new_session();
      fs_cnt = 0;
      guard  = 0;
      while (!m_done && guard < 16) begin
         guard++;
         rnd = 29'($urandom);
         if (fs_cnt < 2 && $urandom_range(0, 4) == 0) begin
            fs_cnt++;
            do_false_start(rnd);
         end else begin
            do_trial(rnd, int'($urandom_range(0, MAX_REACT_T + 1)),
                     int'($urandom_range(1, TICK_DIV)), 1'($urandom_range(0, 1)));
         end
      end
      chk("s2_done", {31'd0, m_done}, 1);

      // session 3: timeout on the first trial, then async reset mid-REACT
      mdl_new_session();
      do_trial(29'($urandom), MAX_REACT_T + 1, 1, 1'b0);
      start_and_wait_led(29'($urandom), ok);
      repeat (3 * TICK_DIV) step();
      chk("pre_reset_cur", bus.cur_cs, 3);
      #2;
      reset = 1'b0;
      #1;
      chk("async_led", bus.led, 0);
      chk("async_disp", bus.disp_sel, 0);
      chk("async_best", bus.best_cs, MAX_REACT_T);
      chk("async_cur", bus.cur_cs, 0);
      chk("async_idx", bus.trial_idx, 0);
      step();
      reset = 1'b1;
      step();

      mdl_new_session();
      do_trial(29'($urandom), int'($urandom_range(0, MAX_REACT_T)), 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
